// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between EXE and WB: one transaction in flight, variable-latency memory
// port with ack, misalignment detection and ack-timeout error reporting.
module lsu_mem_ctrl #(
   parameter int          XLEN        = 64,
   parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
   parameter int          TIMEOUT_CYC = 255
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_wen,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [4:0]      req_rd,
   output logic            mem_en,
   output logic            mem_wen,
   output logic [XLEN-1:0] mem_idx,
   output logic [XLEN-1:0] mem_wdata,
   output logic [XLEN-1:0] mem_wmask,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ack,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_data,
   output logic [4:0]      resp_rd,
   output logic [1:0]      resp_err
);
   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   state_t state, next_state;

   logic            lat_wen, lat_unsigned;
   logic [XLEN-1:0] lat_addr, lat_wdata;
   logic [1:0]      lat_size;
   logic [4:0]      lat_rd;
   logic [15:0]     wait_cnt;
   logic [XLEN-1:0] resp_data_q;
   logic [1:0]      resp_err_q;

   logic            accept, illegal, timeout_hit, sign_bit;
   logic [3:0]      req_off_ext, align_mask;
   logic [OFFW-1:0] off;
   logic [15:0]     base_mask;
   logic [NB-1:0]   byte_mask;
   logic [XLEN-1:0] wmask_full, idx_value, shifted_rdata, low_mask, load_value;

   assign accept      = (state == IDLE) && req_valid;
   assign req_off_ext = 4'(req_addr[OFFW-1:0]);
   assign align_mask  = 4'((4'd1 << req_size) - 4'd1);
   assign illegal     = ((req_off_ext & align_mask) != 4'd0) || ((XLEN == 32) && (req_size == 2'd3));
   assign timeout_hit = (17'(wait_cnt) + 17'd1) == 17'(TIMEOUT_CYC);

   // Lane placement of store data and alignment/extension of load data, all from latched fields
   always_comb begin
      off           = lat_addr[OFFW-1:0];
      base_mask     = (16'd1 << (5'd1 << lat_size)) - 16'd1;
      byte_mask     = NB'(base_mask << off);
      wmask_full    = '0;
      low_mask      = '0;
      for (int b = 0; b < NB; b++) begin
         wmask_full[b*8 +: 8] = {8{byte_mask[b]}};
      end
      idx_value     = (lat_addr - BASE_ADDR[XLEN-1:0]) >> OFFW;
      shifted_rdata = mem_rdata >> {off, 3'b000};
      for (int i = 0; i < XLEN; i++) begin
         low_mask[i] = (i < (8 << lat_size));
      end
      case (lat_size)
         2'd0:    sign_bit = shifted_rdata[7];
         2'd1:    sign_bit = shifted_rdata[15];
         2'd2:    sign_bit = shifted_rdata[31];
         default: sign_bit = 1'b0;
      endcase
      load_value = (shifted_rdata & low_mask) |
                   ((sign_bit && !lat_unsigned) ? ~low_mask : '0);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state and handshake/memory outputs; memory outputs are zero outside REQ
   always_comb begin
      next_state = state;
      req_ready  = 1'b0;
      mem_en     = 1'b0;
      mem_wen    = 1'b0;
      mem_idx    = '0;
      mem_wdata  = '0;
      mem_wmask  = '0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) next_state = illegal ? RESP : REQ;
         end
         REQ: begin
            mem_en    = 1'b1;
            mem_wen   = lat_wen;
            mem_idx   = idx_value;
            mem_wdata = lat_wdata << {off, 3'b000};
            mem_wmask = wmask_full;
            if (mem_ack || timeout_hit) next_state = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Request capture, timeout counting and response registers; ack wins over the timeout limit
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lat_wen      <= 1'b0;
         lat_unsigned <= 1'b0;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         lat_size     <= 2'd0;
         lat_rd       <= 5'd0;
         wait_cnt     <= 16'd0;
         resp_data_q  <= '0;
         resp_err_q   <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  lat_wen      <= req_wen;
                  lat_unsigned <= req_unsigned;
                  lat_addr     <= req_addr;
                  lat_wdata    <= req_wdata;
                  lat_size     <= req_size;
                  lat_rd       <= req_rd;
                  wait_cnt     <= 16'd0;
                  resp_data_q  <= '0;
                  resp_err_q   <= illegal ? 2'd1 : 2'd0;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  resp_data_q <= lat_wen ? '0 : load_value;
                  resp_err_q  <= 2'd0;
               end else if (timeout_hit) begin
                  resp_data_q <= '0;
                  resp_err_q  <= 2'd2;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign resp_data = resp_data_q;
   assign resp_rd   = lat_rd;
   assign resp_err  = resp_err_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed vector table, randomized transactions
// against a reference model, reset-abort sequence and a 32-bit instance.
module tb_lsu_mem_ctrl;
   localparam logic [63:0] BASE = 64'h8000_0000;
   localparam int          TOUT = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic        req_valid, req_ready, req_wen, req_unsigned;
   logic [63:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic [4:0]  req_rd;
   logic        mem_en, mem_wen, mem_ack;
   logic [63:0] mem_idx, mem_wdata, mem_wmask, mem_rdata;
   logic        resp_valid, resp_ready;
   logic [63:0] resp_data;
   logic [4:0]  resp_rd;
   logic [1:0]  resp_err;

   logic        s_req_valid, s_req_ready, s_req_wen, s_req_unsigned;
   logic [31:0] s_req_addr, s_req_wdata;
   logic [1:0]  s_req_size;
   logic [4:0]  s_req_rd;
   logic        s_mem_en, s_mem_wen, s_mem_ack;
   logic [31:0] s_mem_idx, s_mem_wdata, s_mem_wmask, s_mem_rdata;
   logic        s_resp_valid, s_resp_ready;
   logic [31:0] s_resp_data;
   logic [4:0]  s_resp_rd;
   logic [1:0]  s_resp_err;

   int tests  = 0;
   int errors = 0;

   lsu_mem_ctrl #(.XLEN(64), .BASE_ADDR(BASE), .TIMEOUT_CYC(TOUT)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned), .req_rd(req_rd),
      .mem_en(mem_en), .mem_wen(mem_wen), .mem_idx(mem_idx), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_rd(resp_rd), .resp_err(resp_err)
   );

   lsu_mem_ctrl #(.XLEN(32), .BASE_ADDR(BASE), .TIMEOUT_CYC(255)) dut32 (
      .clock(clock), .reset(reset),
      .req_valid(s_req_valid), .req_ready(s_req_ready), .req_wen(s_req_wen), .req_addr(s_req_addr),
      .req_wdata(s_req_wdata), .req_size(s_req_size), .req_unsigned(s_req_unsigned), .req_rd(s_req_rd),
      .mem_en(s_mem_en), .mem_wen(s_mem_wen), .mem_idx(s_mem_idx), .mem_wdata(s_mem_wdata),
      .mem_wmask(s_mem_wmask), .mem_rdata(s_mem_rdata), .mem_ack(s_mem_ack),
      .resp_valid(s_resp_valid), .resp_ready(s_resp_ready), .resp_data(s_resp_data),
      .resp_rd(s_resp_rd), .resp_err(s_resp_err)
   );

   typedef struct {
      logic        wen;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [1:0]  size;
      logic        uns;
      logic [4:0]  rd;
      int          delay;
      logic [63:0] rdata;
      int          hold;
      logic        stray;
      logic [63:0] exp_data;
      logic [1:0]  exp_err;
      int          exp_lat;
      int          exp_en;
      logic [63:0] exp_idx;
      logic [63:0] exp_wdata;
      logic [63:0] exp_wmask;
   } vec_t;

   typedef struct {
      logic [63:0] data;
      logic [1:0]  err;
      logic [4:0]  rd;
      int          lat;
      int          en;
      logic [63:0] idx;
      logic [63:0] wdata;
      logic [63:0] wmask;
      logic        wen;
      logic        stable;
      logic        ready_after;
      logic        timed_out;
   } obs_t;

   function automatic vec_t mkVec(logic wen, logic [63:0] addr, logic [63:0] wdata, logic [1:0] size,
                                  logic uns, logic [4:0] rd, int delay, logic [63:0] rdata, int hold,
                                  logic stray, logic [63:0] exp_data, logic [1:0] exp_err, int exp_lat,
                                  int exp_en, logic [63:0] exp_idx, logic [63:0] exp_wdata,
                                  logic [63:0] exp_wmask);
      vec_t v;
      v.wen = wen; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns; v.rd = rd;
      v.delay = delay; v.rdata = rdata; v.hold = hold; v.stray = stray;
      v.exp_data = exp_data; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_en = exp_en;
      v.exp_idx = exp_idx; v.exp_wdata = exp_wdata; v.exp_wmask = exp_wmask;
      return v;
   endfunction

   // Behavioural model: byte-oriented arithmetic on the request, one ack after 'delay' wait cycles
   function automatic vec_t refModel(vec_t v);
      vec_t        e      = v;
      int          off    = int'(v.addr[2:0]);
      int          nbytes = 1 << v.size;
      logic [63:0] raw, m;
      e.exp_data = 64'd0; e.exp_idx = 64'd0; e.exp_wdata = 64'd0; e.exp_wmask = 64'd0; e.exp_en = 0;
      if ((off % nbytes) != 0) begin
         e.exp_err = 2'd1;
         e.exp_lat = 1;
         return e;
      end
      e.exp_idx   = (v.addr - BASE) / 8;
      e.exp_wdata = v.wdata << (8 * off);
      for (int b = 0; b < 8; b++)
         if (b >= off && b < off + nbytes) e.exp_wmask[8*b +: 8] = 8'hFF;
      if (v.delay + 1 <= TOUT) begin
         e.exp_en  = v.delay + 1;
         e.exp_err = 2'd0;
         if (!v.wen) begin
            raw = v.rdata >> (8 * off);
            if (nbytes == 8) e.exp_data = raw;
            else begin
               m = (64'd1 << (8 * nbytes)) - 64'd1;
               e.exp_data = raw & m;
               if (!v.uns && raw[8*nbytes-1]) e.exp_data = e.exp_data | ~m;
            end
         end
      end else begin
         e.exp_en  = TOUT;
         e.exp_err = 2'd2;
      end
      e.exp_lat = e.exp_en + 1;
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issues one request, plays the memory with the given ack delay, holds resp_ready low 'hold' cycles
   task automatic applyStimulus(input vec_t v, output obs_t o);
      int   r;
      logic done;
      o.data = '0; o.err = '0; o.rd = '0; o.lat = -1; o.en = 0; o.idx = '0; o.wdata = '0;
      o.wmask = '0; o.wen = 1'b0; o.stable = 1'b1; o.ready_after = 1'b0; o.timed_out = 1'b0;
      @(posedge clock); #1;
      req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr; req_wdata = v.wdata;
      req_size = v.size; req_unsigned = v.uns; req_rd = v.rd;
      if (!req_ready) o.stable = 1'b0;
      @(posedge clock); #1;
      req_valid = 1'b0;
      r = 1;
      done = 1'b0;
      while (!done && r <= 40) begin
         if (mem_en) begin
            o.en++;
            if (o.en == 1) begin
               o.idx = mem_idx; o.wdata = mem_wdata; o.wmask = mem_wmask; o.wen = mem_wen;
            end else if (mem_idx !== o.idx || mem_wdata !== o.wdata || mem_wmask !== o.wmask ||
                         mem_wen !== o.wen) o.stable = 1'b0;
            mem_ack   = (o.en == v.delay + 1);
            mem_rdata = v.rdata;
         end else begin
            mem_ack   = v.stray;
            mem_rdata = ~v.rdata;
         end
         if (resp_valid) begin
            if (o.lat < 0) begin
               o.lat = r; o.data = resp_data; o.err = resp_err; o.rd = resp_rd;
            end else if (resp_data !== o.data || resp_err !== o.err || resp_rd !== o.rd)
               o.stable = 1'b0;
            if (req_ready) o.stable = 1'b0;
            resp_ready = ((r - o.lat) >= v.hold);
            done = resp_ready;
         end
         @(posedge clock); #1;
         r++;
      end
      mem_ack = 1'b0;
      resp_ready = 1'b0;
      o.timed_out = !done;
      o.ready_after = req_ready;
   endtask

   task automatic runVector(input vec_t v, input string tag);
      obs_t o;
      applyStimulus(v, o);
      checkOutput({tag, " no_resp"}, 64'(o.timed_out), 64'd0);
      checkOutput({tag, " data"},    o.data, v.exp_data);
      checkOutput({tag, " err"},     64'(o.err), 64'(v.exp_err));
      checkOutput({tag, " rd"},      64'(o.rd), 64'(v.rd));
      checkOutput({tag, " latency"}, 64'(o.lat), 64'(v.exp_lat));
      checkOutput({tag, " en_cyc"},  64'(o.en), 64'(v.exp_en));
      checkOutput({tag, " idx"},     o.idx, v.exp_idx);
      checkOutput({tag, " wdata"},   o.wdata, v.exp_wdata);
      checkOutput({tag, " wmask"},   o.wmask, v.exp_wmask);
      checkOutput({tag, " wen"},     64'(o.wen), (v.exp_en > 0) ? 64'(v.wen) : 64'd0);
      checkOutput({tag, " stable"},  64'(o.stable), 64'd1);
      checkOutput({tag, " rdy_aft"}, 64'(o.ready_after), 64'd1);
   endtask

   task automatic applyStimulus32(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                                  input logic [31:0] rdata, output int lat, output logic [31:0] data,
                                  output logic [1:0] err, output logic [31:0] idx);
      lat = -1; data = '0; err = '0; idx = '0;
      @(posedge clock); #1;
      s_req_valid = 1'b1; s_req_addr = addr; s_req_size = size; s_req_unsigned = uns; s_req_wen = 1'b0;
      @(posedge clock); #1;
      s_req_valid = 1'b0;
      for (int r = 1; r <= 10 && lat < 0; r++) begin
         s_mem_ack = s_mem_en;
         s_mem_rdata = rdata;
         if (s_mem_en) idx = s_mem_idx;
         if (s_resp_valid) begin
            lat = r; data = s_resp_data; err = s_resp_err; s_resp_ready = 1'b1;
         end
         @(posedge clock); #1;
      end
      s_resp_ready = 1'b0;
      s_mem_ack = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t        dir [12];
      vec_t        v;
      logic        seen;
      int          lat32;
      logic [31:0] d32, i32;
      logic [1:0]  e32;
      logic [63:0] ones = '1;

      req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_size = 0; req_unsigned = 0; req_rd = 0;
      mem_rdata = 0; mem_ack = 0; resp_ready = 0;
      s_req_valid = 0; s_req_wen = 0; s_req_addr = 0; s_req_wdata = 0; s_req_size = 0;
      s_req_unsigned = 0; s_req_rd = 0; s_mem_rdata = 0; s_mem_ack = 0; s_resp_ready = 0;

      dir[0]  = mkVec(0, 64'h8000_0013, 64'h0, 2'd0, 0, 5'd1, 0, 64'h0000_0000_8F00_0000, 0, 0,
                      64'hFFFF_FFFF_FFFF_FF8F, 2'd0, 2, 1, 64'd2, 64'h0, 64'h0000_0000_FF00_0000);
      dir[1]  = mkVec(1, 64'h8000_0004, 64'h1234_5678, 2'd2, 0, 5'd2, 2, 64'h0, 0, 0,
                      64'h0, 2'd0, 4, 3, 64'd0, 64'h1234_5678_0000_0000, 64'hFFFF_FFFF_0000_0000);
      dir[2]  = mkVec(0, 64'h8000_0006, 64'h0, 2'd2, 0, 5'd3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0,
                      64'h0, 2'd1, 1, 0, 64'd0, 64'h0, 64'h0);
      dir[3]  = mkVec(0, 64'h8000_0008, 64'h0, 2'd3, 0, 5'd4, 10, 64'h1111, 0, 1,
                      64'h0, 2'd2, 5, 4, 64'd1, 64'h0, ones);
      dir[4]  = mkVec(0, 64'h8000_0010, 64'h0, 2'd3, 0, 5'd5, 1, 64'hDEAD_BEEF_0123_4567, 0, 0,
                      64'hDEAD_BEEF_0123_4567, 2'd0, 3, 2, 64'd2, 64'h0, ones);
      dir[5]  = mkVec(0, 64'h8000_0002, 64'h0, 2'd1, 1, 5'd6, 0, 64'h0000_0000_8001_0000, 5, 0,
                      64'h8001, 2'd0, 2, 1, 64'd0, 64'h0, 64'h0000_0000_FFFF_0000);
      dir[6]  = mkVec(0, 64'h8000_0000, 64'h0, 2'd2, 1, 5'd7, 0, 64'h0000_0000_F234_5678, 0, 0,
                      64'h0000_0000_F234_5678, 2'd0, 2, 1, 64'd0, 64'h0, 64'h0000_0000_FFFF_FFFF);
      dir[7]  = mkVec(0, 64'h8000_0000, 64'h0, 2'd2, 0, 5'd8, 0, 64'h0000_0000_F234_5678, 0, 0,
                      64'hFFFF_FFFF_F234_5678, 2'd0, 2, 1, 64'd0, 64'h0, 64'h0000_0000_FFFF_FFFF);
      dir[8]  = mkVec(0, 64'h8000_0006, 64'h0, 2'd1, 0, 5'd9, 0, 64'h8123_0000_0000_0000, 0, 0,
                      64'hFFFF_FFFF_FFFF_8123, 2'd0, 2, 1, 64'd0, 64'h0, 64'hFFFF_0000_0000_0000);
      dir[9]  = mkVec(1, 64'h8000_001F, 64'hAB, 2'd0, 0, 5'd10, 0, 64'h0, 0, 0,
                      64'h0, 2'd0, 2, 1, 64'd3, 64'hAB00_0000_0000_0000, 64'hFF00_0000_0000_0000);
      dir[10] = mkVec(0, 64'h8000_0004, 64'h0, 2'd3, 0, 5'd11, 0, 64'h0, 0, 0,
                      64'h0, 2'd1, 1, 0, 64'd0, 64'h0, 64'h0);
      dir[11] = mkVec(1, 64'h8000_0100, 64'h0123_4567_89AB_CDEF, 2'd3, 0, 5'd12, 3, 64'h0, 1, 0,
                      64'h0, 2'd0, 5, 4, 64'h20, 64'h0123_4567_89AB_CDEF, ones);

      // Reset state: quiet memory/response ports while held, ready once released
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset mem_en", 64'(mem_en), 64'd0);
      checkOutput("reset resp_valid", 64'(resp_valid), 64'd0);
      reset = 1'b0;
      @(posedge clock); #1;
      checkOutput("reset req_ready", 64'(req_ready), 64'd1);
      checkOutput("reset resp_data", resp_data, 64'd0);
      checkOutput("reset resp_err", 64'(resp_err), 64'd0);

      for (int i = 0; i < 12; i++) runVector(dir[i], $sformatf("dir%0d", i));

      for (int i = 0; i < 60; i++) begin
         v.wen   = 1'($urandom_range(0, 1));
         v.size  = 2'($urandom_range(0, 3));
         v.addr  = BASE + 64'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) v.addr = v.addr & ~((64'd1 << v.size) - 64'd1);
         v.wdata = {$urandom, $urandom};
         v.rdata = {$urandom, $urandom};
         v.uns   = 1'($urandom_range(0, 1));
         v.rd    = 5'($urandom_range(0, 31));
         v.delay = $urandom_range(0, 5);
         v.hold  = $urandom_range(0, 2);
         v.stray = 1'($urandom_range(0, 1));
         v = refModel(v);
         runVector(v, $sformatf("rnd%0d", i));
      end

      // Reset while waiting for ack aborts the access without a response
      @(posedge clock); #1;
      req_valid = 1'b1; req_wen = 1'b0; req_addr = BASE; req_size = 2'd3; req_rd = 5'd1;
      @(posedge clock); #1;
      req_valid = 1'b0;
      checkOutput("rst in_req mem_en", 64'(mem_en), 64'd1);
      @(posedge clock); #2;
      reset = 1'b1;
      #1;
      checkOutput("rst async mem_en", 64'(mem_en), 64'd0);
      checkOutput("rst async resp_valid", 64'(resp_valid), 64'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;
      checkOutput("rst after req_ready", 64'(req_ready), 64'd1);
      seen = 1'b0;
      repeat (6) begin
         mem_ack = 1'b1;
         if (resp_valid || mem_en) seen = 1'b1;
         @(posedge clock); #1;
      end
      mem_ack = 1'b0;
      checkOutput("rst no response", 64'(seen), 64'd0);

      applyStimulus32(32'h8000_0000, 2'd3, 1'b0, 32'h1234_5678, lat32, d32, e32, i32);
      checkOutput("x32 size3 err", 64'(e32), 64'd1);
      checkOutput("x32 size3 latency", 64'(lat32), 64'd1);
      applyStimulus32(32'h8000_0004, 2'd2, 1'b0, 32'h8000_0001, lat32, d32, e32, i32);
      checkOutput("x32 lw data", 64'(d32), 64'h8000_0001);
      checkOutput("x32 lw idx", 64'(i32), 64'd1);
      checkOutput("x32 lw latency", 64'(lat32), 64'd2);
      applyStimulus32(32'h8000_0002, 2'd1, 1'b0, 32'h8001_0000, lat32, d32, e32, i32);
      checkOutput("x32 lh data", 64'(d32), 64'hFFFF_8001);
      checkOutput("x32 lh err", 64'(e32), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
